// File: rtl/text_buffer_rom_succ_if.sv
// Bus bundle for text_buffer_rom_succ: pixel-side read port, terminal write port,
// clear request and status. master = driver/host side, slave = the buffer.
interface text_buffer_rom_succ_if #(
    parameter int COLS   = 16,
    parameter int ROWS   = 16,
    parameter int CODE_W = 7
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);

    logic [ROW_W+COL_W-1:0] char_xy;
    logic [CODE_W-1:0]      char_code;
    logic                   wr_en;
    logic [CODE_W-1:0]      wr_char;
    logic                   clr;
    logic                   busy;
    logic [ROW_W+COL_W-1:0] cursor_xy;

    modport master (
        output char_xy, wr_en, wr_char, clr,
        input  char_code, busy, cursor_xy
    );

    modport slave (
        input  char_xy, wr_en, wr_char, clr,
        output char_code, busy, cursor_xy
    );
endinterface

// File: rtl/text_buffer_rom_succ.sv
// Writable, scrolling character buffer replacing the fixed text-overlay character ROM.
// Scrolling at the bottom row is compiled in only when TEXT_BUF_SCROLL_EN is defined.
module text_buffer_rom_succ #(
    parameter int                COLS   = 16,
    parameter int                ROWS   = 16,
    parameter int                CODE_W = 7,
    parameter logic [CODE_W-1:0] BLANK  = CODE_W'(7'h20)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    text_buffer_rom_succ_if.slave bus
);
    localparam int COL_W = $clog2(COLS);
    localparam int ROW_W = $clog2(ROWS);
    localparam int CNT_W = ROW_W + COL_W;
    localparam int DEPTH = COLS * ROWS;

    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(COLS - 1);
    localparam logic [COL_W-1:0]  COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0]  COL_ZERO = COL_W'(0);
    localparam logic [ROW_W-1:0]  ROW_LAST = ROW_W'(ROWS - 1);
    localparam logic [ROW_W-1:0]  ROW_ONE  = ROW_W'(1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
    localparam logic [CODE_W-1:0] CH_LF    = CODE_W'(8'h0A);
    localparam logic [CODE_W-1:0] CH_CR    = CODE_W'(8'h0D);

`ifdef TEXT_BUF_SCROLL_EN
    typedef enum logic [1:0] {
        ST_CLR_ALL = 2'd0,
        ST_IDLE    = 2'd1,
        ST_CLR_ROW = 2'd2
    } state_t;
`else
    typedef enum logic [1:0] {
        ST_CLR_ALL = 2'd0,
        ST_IDLE    = 2'd1
    } state_t;
`endif

    logic [CODE_W-1:0] r_mem [0:DEPTH-1];

    state_t            r_state;
    logic              r_busy;
    logic [CNT_W-1:0]  r_cnt;
    logic [ROW_W-1:0]  r_row;
    logic [COL_W-1:0]  r_col;
    logic [ROW_W-1:0]  r_top;
    logic [CODE_W-1:0] r_char_code;

    state_t            w_state_nxt;
    logic [CNT_W-1:0]  w_cnt_nxt;
    logic [ROW_W-1:0]  w_row_nxt;
    logic [COL_W-1:0]  w_col_nxt;
    logic [ROW_W-1:0]  w_top_nxt;
    logic              w_adv;
    logic              w_mem_we;
    logic [CNT_W-1:0]  w_mem_addr;
    logic [CODE_W-1:0] w_mem_data;
    logic [ROW_W-1:0]  w_wr_prow;
    logic [ROW_W-1:0]  w_rd_prow;
    logic [CNT_W-1:0]  w_rd_addr;

    // Logical rows map to physical rows through the scroll origin; the sum wraps in ROW_W bits.
    assign w_wr_prow = r_row + r_top;
    assign w_rd_prow = bus.char_xy[CNT_W-1:COL_W] + r_top;
    assign w_rd_addr = {w_rd_prow, bus.char_xy[COL_W-1:0]};

    assign bus.char_code = r_char_code;
    assign bus.busy      = r_busy;
    assign bus.cursor_xy = {r_row, r_col};

    // Next-state, cursor movement and RAM write-port selection.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_row_nxt   = r_row;
        w_col_nxt   = r_col;
        w_top_nxt   = r_top;
        w_adv       = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = r_cnt;
        w_mem_data  = BLANK;
        case (r_state)
            ST_CLR_ALL: begin
                w_mem_we = 1'b1;
                if (r_cnt == CNT_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_IDLE: begin
                if (bus.clr) begin
                    w_row_nxt   = '0;
                    w_col_nxt   = '0;
                    w_top_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_state_nxt = ST_CLR_ALL;
                end else if (bus.wr_en) begin
                    if (bus.wr_char == CH_LF) begin
                        w_col_nxt = '0;
                        w_adv     = 1'b1;
                    end else if (bus.wr_char == CH_CR) begin
                        w_col_nxt = '0;
                    end else begin
                        w_mem_we   = 1'b1;
                        w_mem_addr = {w_wr_prow, r_col};
                        w_mem_data = bus.wr_char;
                        if (r_col == COL_LAST) begin
                            w_col_nxt = '0;
                            w_adv     = 1'b1;
                        end else begin
                            w_col_nxt = r_col + COL_ONE;
                        end
                    end
                    if (w_adv) begin
                        if (r_row != ROW_LAST) begin
                            w_row_nxt = r_row + ROW_ONE;
                        end else begin
`ifdef TEXT_BUF_SCROLL_EN
                            // Old top row becomes the new bottom row and is blanked.
                            w_top_nxt   = r_top + ROW_ONE;
                            w_cnt_nxt   = {r_top, COL_ZERO};
                            w_state_nxt = ST_CLR_ROW;
`else
                            w_row_nxt = '0;
`endif
                        end
                    end else begin
                        w_row_nxt = r_row;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
`ifdef TEXT_BUF_SCROLL_EN
            ST_CLR_ROW: begin
                w_mem_we = 1'b1;
                if (r_cnt[COL_W-1:0] == COL_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = '0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
`endif
            default: begin
                w_state_nxt = ST_CLR_ALL;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // Control state, cursor and scroll origin registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_CLR_ALL;
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_row   <= '0;
            r_col   <= '0;
            r_top   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_busy  <= (w_state_nxt != ST_IDLE);
            r_cnt   <= w_cnt_nxt;
            r_row   <= w_row_nxt;
            r_col   <= w_col_nxt;
            r_top   <= w_top_nxt;
        end
    end

    // Character RAM write port; storage itself is not reset.
    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    // Registered read port, read-before-write against a same-cycle store.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_char_code <= '0;
        end else begin
            r_char_code <= r_mem[w_rd_addr];
        end
    end
endmodule

// File: tb/tb_text_buffer_rom_succ.sv
// Self-checking bench for text_buffer_rom_succ against a logical-screen model
// (row shifting on scroll); honours TEXT_BUF_SCROLL_EN like the design.
module tb_text_buffer_rom_succ;
    localparam int COLS   = 16;
    localparam int ROWS   = 16;
    localparam int CODE_W = 7;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    text_buffer_rom_succ_if #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W)) tb_if ();

    text_buffer_rom_succ #(.COLS(COLS), .ROWS(ROWS), .CODE_W(CODE_W), .BLANK(7'h20)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (tb_if)
    );

    always #5 clk = ~clk;

    logic [6:0] scr [ROWS][COLS];
    int         m_row;
    int         m_col;

    function automatic void m_clear();
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                scr[r][c] = 7'h20;
        m_row = 0;
        m_col = 0;
    endfunction

    // Terminal semantics on a logical screen; returns 1 when a scroll happened.
    function automatic bit m_write(input logic [6:0] ch);
        bit adv = 1'b0;
        bit scrolled = 1'b0;
        if (ch == 7'h0A) begin
            m_col = 0;
            adv = 1'b1;
        end else if (ch == 7'h0D) begin
            m_col = 0;
        end else begin
            scr[m_row][m_col] = ch;
            if (m_col == COLS - 1) begin
                m_col = 0;
                adv = 1'b1;
            end else begin
                m_col++;
            end
        end
        if (adv) begin
            if (m_row < ROWS - 1) begin
                m_row++;
            end else begin
`ifdef TEXT_BUF_SCROLL_EN
                for (int r = 0; r < ROWS - 1; r++)
                    for (int c = 0; c < COLS; c++)
                        scr[r][c] = scr[r+1][c];
                for (int c = 0; c < COLS; c++)
                    scr[ROWS-1][c] = 7'h20;
                scrolled = 1'b1;
`else
                m_row = 0;
`endif
            end
        end
        return scrolled;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_idle(input string tag, input int exp_n);
        int n = 0;
        while (tb_if.busy === 1'b1 && n < 1000) begin
            step();
            n++;
        end
        check(tag, n, exp_n);
    endtask

    task automatic do_write(input logic [6:0] ch);
        bit sc;
        tb_if.wr_en   = 1'b1;
        tb_if.wr_char = ch;
        step();
        tb_if.wr_en = 1'b0;
        sc = m_write(ch);
        check("wr_cursor", tb_if.cursor_xy, m_row * COLS + m_col);
        check("wr_busy", tb_if.busy, sc);
        if (sc) wait_idle("scroll_busy_len", COLS);
    endtask

    task automatic read_check(input string tag, input int addr);
        tb_if.char_xy = addr[7:0];
        step();
        check(tag, tb_if.char_code, scr[addr / COLS][addr % COLS]);
    endtask

    task automatic sweep(input string tag);
        for (int a = 0; a < ROWS * COLS; a++) read_check(tag, a);
    endtask

    task automatic do_clear();
        tb_if.clr = 1'b1;
        step();
        tb_if.clr = 1'b0;
        check("clr_busy_rise", tb_if.busy, 1);
        wait_idle("clr_busy_len", ROWS * COLS);
        m_clear();
        check("clr_cursor", tb_if.cursor_xy, 0);
    endtask

    initial begin
        tb_if.char_xy = '0;
        tb_if.wr_en   = 1'b0;
        tb_if.wr_char = '0;
        tb_if.clr     = 1'b0;
        m_clear();

        // Reset state and power-on clear.
        step();
        check("rst_busy", tb_if.busy, 1);
        check("rst_char_code", tb_if.char_code, 0);
        check("rst_cursor", tb_if.cursor_xy, 0);
        rst_n = 1'b1;
        wait_idle("por_busy_len", ROWS * COLS);
        sweep("por_blank");

        // "Hi"
        do_write(7'h48);
        do_write(7'h69);
        read_check("hi_0", 8'h00);
        read_check("hi_1", 8'h01);
        check("hi_cursor", tb_if.cursor_xy, 8'h02);

        // Line wrap followed by LF leaves row 1 empty.
        do_clear();
        for (int i = 0; i < 15; i++) do_write(7'h41);
        do_write(7'h42);
        do_write(7'h0A);
        do_write(7'h43);
        read_check("wrap_0f", 8'h0F);
        read_check("wrap_10", 8'h10);
        read_check("wrap_20", 8'h20);
        check("wrap_cursor", tb_if.cursor_xy, 8'h21);
        check("wrap_0f_val", scr[0][15], 7'h42);

        // Read-before-write at the same address.
        do_clear();
        tb_if.char_xy = 8'h00;
        tb_if.wr_en   = 1'b1;
        tb_if.wr_char = 7'h55;
        step();
        tb_if.wr_en = 1'b0;
        void'(m_write(7'h55));
        check("rbw_old", tb_if.char_code, 7'h20);
        step();
        check("rbw_new", tb_if.char_code, 7'h55);

        // Fill the whole screen, then write past the bottom.
        do_clear();
        for (int i = 0; i < ROWS * COLS - 1; i++) do_write(7'h41);
`ifdef TEXT_BUF_SCROLL_EN
        tb_if.wr_en   = 1'b1;
        tb_if.wr_char = 7'h41;
        step();
        void'(m_write(7'h41));
        check("fill_scroll_busy", tb_if.busy, 1);
        tb_if.wr_char = 7'h42;
        step();
        tb_if.wr_en = 1'b0;
        wait_idle("fill_scroll_rest", COLS - 1);
        check("fill_scroll_cursor", tb_if.cursor_xy, 8'hF0);
        sweep("fill_scroll_screen");
        do_write(7'h42);
        read_check("fill_scroll_f0", 8'hF0);
        check("fill_scroll_f0_val", scr[15][0], 7'h42);
`else
        do_write(7'h41);
        do_write(7'h42);
        read_check("fill_wrap_00", 8'h00);
        check("fill_wrap_00_val", scr[0][0], 7'h42);
        check("fill_wrap_cursor", tb_if.cursor_xy, 8'h01);
`endif

        // Randomized text with LF/CR and random read-back.
        for (int i = 0; i < 500; i++) begin
            int sel;
            logic [6:0] ch;
            sel = $urandom_range(0, 15);
            if (sel == 0) ch = 7'h0A;
            else if (sel == 1) ch = 7'h0D;
            else ch = 7'($urandom_range(33, 126));
            do_write(ch);
            if ((i % 8) == 7) read_check("rand_read", $urandom_range(0, ROWS * COLS - 1));
        end
        sweep("rand_screen");

        // clr and wr_en in the same cycle: write dropped, full clear.
        tb_if.wr_en   = 1'b1;
        tb_if.wr_char = 7'h58;
        do_clear();
        tb_if.wr_en = 1'b0;
        sweep("clr_screen");

        // Reset in the middle of a clear restarts the full window.
        do_write(7'h51);
        tb_if.clr = 1'b1;
        step();
        tb_if.clr = 1'b0;
        for (int i = 0; i < 40; i++) step();
        rst_n = 1'b0;
        #1;
        check("midrst_busy", tb_if.busy, 1);
        check("midrst_char_code", tb_if.char_code, 0);
        check("midrst_cursor", tb_if.cursor_xy, 0);
        step();
        rst_n = 1'b1;
        wait_idle("midrst_busy_len", ROWS * COLS);
        m_clear();
        sweep("midrst_screen");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/text_buffer_rom_succ.md
# text_buffer_rom_succ

Writable, scrolling character buffer that replaces the fixed 16x16 character ROM in the text overlay path. The pixel side reads it exactly as before: a `{row, col}` address in, a 7-bit character code out. A terminal-style write port appends characters at a cursor and handles newline, carriage return, line wrap and, optionally, scrolling. Screen clearing runs in hardware and is reported through a `busy` handshake.

## Interface
Parameters
- `COLS`, default 16: characters per row; power of two, at least 2.
- `ROWS`, default 16: rows; power of two, at least 2.
- `CODE_W`, default 7: character code width.
- `BLANK`, default 7'h20: fill code used by clears.

Derived widths: `COL_W = $clog2(COLS)`, `ROW_W = $clog2(ROWS)`.

Ports
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `char_xy`  in  ROW_W+COL_W  read address `{row, col}`; row is the logical (on-screen) row.
- `char_code`  out  CODE_W  registered read data.
- `wr_en`  in  1  write strobe; accepted only when `busy`=0.
- `wr_char`  in  CODE_W  character to append.
- `clr`  in  1  clear-screen request; accepted only when `busy`=0.
- `busy`  out  1  high while a hardware clear runs.
- `cursor_xy`  out  ROW_W+COL_W  logical cursor position `{row, col}`.

## Operation
- Storage: COLS*ROWS x CODE_W RAM. `top` register (ROW_W bits) names the physical row shown as logical row 0.
- Physical row for any access = `(logical_row + top) mod ROWS`. The addition wraps naturally in ROW_W bits.
- FSM states:
  - CLR_ALL: writes BLANK to the address given by counter `cnt`, one location per cycle, for COLS*ROWS cycles, then goes to IDLE.
  - IDLE: accepts `wr_en` and `clr`.
  - CLR_ROW: writes BLANK to COLS locations of one physical row, one per cycle, then goes to IDLE.
  - `busy` = (state != IDLE).
- IDLE with `clr`=1: `cursor`=0, `top`=0, `cnt`=0, next state CLR_ALL. If `wr_en` is high in the same cycle, the write is dropped.
- IDLE with `wr_en`=1:
  - `wr_char`=0x0A (LF): nothing is stored; `col`=0; row advances.
  - `wr_char`=0x0D (CR): nothing is stored; `col`=0.
  - Any other code: stored at the cursor. Then `col`+1; if `col` was COLS-1, `col`=0 and row advances.
- Row advance:
  - `row`<ROWS-1: `row`+1.
  - `row`=ROWS-1 with scroll enabled: `row` stays ROWS-1; `top`+1; next state CLR_ROW, which clears the physical row that was `top` before the increment (the new bottom row).
  - `row`=ROWS-1 without scroll: see Configuration.
- `wr_en` or `clr` asserted while `busy`=1 is ignored: not queued, no side effect.
- Read port: active in every state. `char_code` = RAM[physical(`char_xy`)], captured on each edge. Content is undefined until the first CLR_ALL completes.

## Timing
- Reset values: `char_code`=0, `cursor_xy`=0, `top`=0, `cnt`=0. State is CLR_ALL, so `busy`=1 immediately.
- After `rst_n` rises, `busy` stays 1 for exactly COLS*ROWS edges, then falls.
- Read latency is 1 cycle. On a same-address read and write in the same cycle, the read returns the old data (read-before-write). The new data is visible on the next read.
- Write latency: the RAM and `cursor_xy` update on the edge that samples `wr_en`=1.
- Scroll: `busy` rises on the edge that accepts the wrapping write and stays high for COLS cycles. `top` updates on that same edge.
- `clr` accepted: `busy` rises on the next edge and stays high for COLS*ROWS cycles.
- Reset mid-operation: any clear is aborted and the FSM restarts CLR_ALL from `cnt`=0.

## Configuration
- Macro `TEXT_BUF_SCROLL_EN`.
- Defined: row advance at ROWS-1 scrolls as described, and the CLR_ROW state exists.
- Undefined:
  - CLR_ROW is not compiled and `top` is held at 0.
  - Row advance at ROWS-1 sets `row`=0; the cursor lands on (0,0) and old content is overwritten without clearing.
  - `busy` is asserted only by CLR_ALL.

## Test plan
Use COLS=ROWS=16.
- Reset release: `busy`=1 for 256 cycles, then 0. All 256 addresses then read 0x20, each one cycle after its address is applied.
- Write 0x48, 0x69: `char_xy`=0x00 reads 0x48, 0x01 reads 0x69, `cursor_xy`=0x02.
- Write 15x 0x41, then 0x42, then 0x0A, then 0x43 from the cursor at 0x00: 0x0F reads 0x42, 0x10 reads 0x20, 0x20 reads 0x43, `cursor_xy`=0x21. The line wrap plus LF leaves row 1 empty.
- With scroll enabled, write 256x 0x41 and then 0x42:
  - `busy`=1 for 16 cycles after the 256th write; the 0x42 presented during that window is dropped.
  - After `busy` falls, 0xF0–0xFF read 0x20 and 0x00 reads 0x41.
  - Writing 0x42 again places it at 0xF0.
- Same sequence with scroll disabled: `busy` never rises; the 257th write (0x42) lands at 0x00; `cursor_xy`=0x01.
- `clr` and `wr_en` in the same IDLE cycle: the write is dropped, `busy`=1 for 256 cycles, then `cursor_xy`=0 and all addresses read 0x20. Asserting `rst_n`=0 mid-clear restarts the 256-cycle `busy` window.
